// File: rtl/alu_req_scheduler_pkg.sv
// Shared opcode, state and width definitions for the ALU request scheduler.
package alu_req_scheduler_pkg;

  localparam int unsigned WIDTH_DEF = 18;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_scheduler_alu.sv
// Shared four-function ALU datapath (AND/ADD/OR/XOR); purely combinational.
module alu_req_scheduler_alu
  import alu_req_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op)
      OP_AND:  result_c = a & b;
      OP_ADD:  result_c = a + b;
      OP_OR:   result_c = a | b;
      default: result_c = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters, with a
// held response register and a saturating completion counter.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic             rr_last;
  logic             gnt;
  logic             accept;
  logic [WIDTH-1:0] alu_res_c;
  logic [WIDTH:0]   sum_c;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) gnt = ~rr_last;
    else                    gnt = req_valid[1];
  end

  assign accept = (state == S_IDLE) && (|req_valid);
  assign busy   = (state != S_IDLE);
  assign sum_c  = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  alu_req_scheduler_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result_c (alu_res_c)
  );

  // Operand capture, response register and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      id_q       <= 1'b0;
      rr_last    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= gnt ? req_a1 : req_a0;
        b_q     <= gnt ? req_b1 : req_b0;
        op_q    <= gnt ? req_op1 : req_op0;
        id_q    <= gnt;
        rr_last <= gnt;
      end
      if (state == S_EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_res_c;
        rsp_carry  <= (op_q == OP_ADD) && sum_c[WIDTH];
        rsp_id     <= id_q;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [17:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_op0, req_op1;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_id, busy;
  logic [17:0] rsp_result;
  logic [15:0] op_count;

  logic [1:0]  sat_req_ready;
  logic        sat_rsp_valid, sat_rsp_carry, sat_rsp_id, sat_busy;
  logic [17:0] sat_rsp_result;
  logic [1:0]  sat_op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_scheduler u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  alu_req_scheduler #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(sat_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(sat_rsp_result),
    .rsp_carry(sat_rsp_carry), .rsp_id(sat_rsp_id), .busy(sat_busy),
    .op_count(sat_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // One isolated operation from a single requester with an immediate accept.
  task automatic do_op(input logic id, input logic [17:0] a, input logic [17:0] b,
                       input logic [1:0] op, input logic [17:0] exp_r,
                       input logic exp_c, input int exp_cnt);
    @(negedge clk);
    if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; req_valid = 2'b10; end
    else    begin req_a0 = a; req_b0 = b; req_op0 = op; req_valid = 2'b01; end
    #1;
    chk("op_ready", 32'(req_ready), id ? 32'd2 : 32'd1);
    chk("op_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    req_a0 = ~a; req_b0 = ~b; req_op0 = ~op;
    req_a1 = ~a; req_b1 = ~b; req_op1 = ~op;
    chk("op_exec_busy", 32'(busy), 32'd1);
    chk("op_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op_result", 32'(rsp_result), 32'(exp_r));
    chk("op_carry", 32'(rsp_carry), 32'(exp_c));
    chk("op_id", 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("op_done_valid", 32'(rsp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("sat_count", 32'(sat_op_count), 32'(sat3(exp_cnt)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = 2'b00;
    req_a1 = '0; req_b1 = '0; req_op1 = 2'b00;

    // T1 reset
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    reset = 1'b0;

    // T2 each opcode
    do_op(1'b0, 18'h2AAAA, 18'h15555, 2'b00, 18'h00000, 1'b0, 1);
    do_op(1'b0, 18'h2AAAA, 18'h15555, 2'b10, 18'h3FFFF, 1'b0, 2);
    do_op(1'b0, 18'h2AAAA, 18'h15555, 2'b11, 18'h3FFFF, 1'b0, 3);
    do_op(1'b0, 18'h2AAAA, 18'h15555, 2'b01, 18'h3FFFF, 1'b0, 4);

    // T3 carry out of ADD from requester 1
    do_op(1'b1, 18'h3FFFF, 18'h00001, 2'b01, 18'h00000, 1'b1, 5);

    // T4 contention from a fresh reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    req_a0 = 18'h00F0F; req_b0 = 18'h0FF00; req_op0 = 2'b00;
    req_a1 = 18'h3F0F0; req_b1 = 18'h0FFFF; req_op1 = 2'b11;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    chk("t4_rst_count", 32'(op_count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      chk("t4_exec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp_id", 32'(rsp_id), 32'(k % 2));
      chk("t4_result", 32'(rsp_result), (k % 2 == 0) ? 32'h00F00 : 32'h30F0F);
      @(negedge clk);
      chk("t4_count", 32'(op_count), 32'(k + 1));
      chk("t4_sat_count", 32'(sat_op_count), 32'(sat3(k + 1)));
    end
    req_valid = 2'b00; rsp_ready = 1'b0;

    // T5 response backpressure with competing requests held
    @(negedge clk);
    req_a1 = 18'h12345; req_b1 = 18'h00F00; req_op1 = 2'b10; req_valid = 2'b10;
    #1;
    chk("t5_grant", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("t5_exec_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid", 32'(rsp_valid), 32'd1);
      chk("t5_result", 32'(rsp_result), 32'h12F45);
      chk("t5_id", 32'(rsp_id), 32'd1);
      chk("t5_carry", 32'(rsp_carry), 32'd0);
      chk("t5_ready", 32'(req_ready), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t5_done_valid", 32'(rsp_valid), 32'd0);
    chk("t5_done_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(op_count), 32'd5);
    chk("t5_sat_count", 32'(sat_op_count), 32'd3);

    // T6 reset while an operation is executing
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_a0 = 18'h3FFFF; req_b0 = 18'h00001; req_op0 = 2'b01; req_valid = 2'b01;
    #1;
    chk("t6_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00; reset = 1'b1;
    chk("t6_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(rsp_valid), 32'd0);
    chk("t6_count", 32'(op_count), 32'd0);
    chk("t6_sat_count", 32'(sat_op_count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
